// File: rtl/vga_ball_mover.sv
// Ball motion controller and write-port arbiter for the VGA ball peripheral.
// Latency: an arbitration decision appears on write/address/writedata one cycle later.
// Backpressure: host writes always win; a stalled mover write retries every cycle.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   enable             1 allows frame-driven motion updates
//   VGA_VS             active-low vertical sync; its falling edge is the frame tick
//   host_*             host write port (chipselect, write, address, writedata)
//   chipselect/write   registered write strobe to the peripheral (identical signals)
//   address/writedata  registered write fields; they hold when no write is granted
//   busy               high while a motion update sequence is in progress
//   ball_x, ball_y     current position register values
module vga_ball_mover #(
    parameter int unsigned XMIN      = 20,
    parameter int unsigned XMAX      = 235,
    parameter int unsigned YMIN      = 13,
    parameter int unsigned YMAX      = 107,
    parameter int unsigned DX        = 1,
    parameter int unsigned DY        = 1,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       VGA_VS,
    input  logic       host_chipselect,
    input  logic       host_write,
    input  logic [2:0] host_address,
    input  logic [7:0] host_writedata,
    output logic       chipselect,
    output logic       write,
    output logic [2:0] address,
    output logic [7:0] writedata,
    output logic       busy,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y
);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WR_X, S_WR_Y} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_vs_d;
    logic [7:0] r_div_cnt;
    logic [7:0] r_ball_x;
    logic [7:0] r_ball_y;
    logic       r_dir_x;      // 1 = increasing
    logic       r_dir_y;
    logic       r_write;
    logic [2:0] r_address;
    logic [7:0] r_writedata;

    logic       w_host_wr;
    logic       w_tick;
    logic       w_div_hit;
    logic       w_mov_wr;
    logic [2:0] w_mov_addr;
    logic [7:0] w_mov_dat;
    logic [8:0] w_x_step;     // {new_dir, new_pos}
    logic [8:0] w_y_step;

    // One axis step with bounce. Comparisons are done at 9 bits so a
    // host-written value near 255 or 0 is clamped instead of wrapping.
    function automatic logic [8:0] f_step(input logic [7:0] pos, input logic dir,
                                          input logic [7:0] d, input logic [7:0] mn,
                                          input logic [7:0] mx);
        logic [8:0] res;
        res = {dir, pos};
        if (dir) begin
            if ({1'b0, pos} + {1'b0, d} >= {1'b0, mx}) res = {1'b0, mx};
            else                                       res = {1'b1, pos + d};
        end else begin
            if ({1'b0, pos} <= {1'b0, mn} + {1'b0, d}) res = {1'b1, mn};
            else                                       res = {1'b0, pos - d};
        end
        return res;
    endfunction

    assign w_host_wr = host_chipselect && host_write;
    assign w_tick    = r_vs_d && !VGA_VS;
    assign w_div_hit = (r_div_cnt == 8'(FRAME_DIV - 1));
    assign w_x_step  = f_step(r_ball_x, r_dir_x, 8'(DX), 8'(XMIN), 8'(XMAX));
    assign w_y_step  = f_step(r_ball_y, r_dir_y, 8'(DY), 8'(YMIN), 8'(YMAX));

    always_comb begin
        w_state_nxt = r_state;
        w_mov_wr    = 1'b0;
        w_mov_addr  = 3'd3;
        w_mov_dat   = r_ball_x;
        case (r_state)
            S_IDLE:   if (w_tick && enable && w_div_hit) w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_WR_X;
            S_WR_X: begin
                if (!w_host_wr) begin
                    w_mov_wr    = 1'b1;
                    w_state_nxt = S_WR_Y;
                end
            end
            S_WR_Y: begin
                w_mov_addr = 3'd4;
                w_mov_dat  = r_ball_y;
                if (!w_host_wr) begin
                    w_mov_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_vs_d      <= 1'b1;
            r_div_cnt   <= 8'd0;
            r_ball_x    <= 8'd128;
            r_ball_y    <= 8'd60;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_write     <= 1'b0;
            r_address   <= 3'd0;
            r_writedata <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_vs_d  <= VGA_VS;

            if (r_state == S_IDLE && w_tick && enable)
                r_div_cnt <= w_div_hit ? 8'd0 : r_div_cnt + 8'd1;

            if (r_state == S_UPDATE) begin
                r_ball_x <= w_x_step[7:0];
                r_dir_x  <= w_x_step[8];
                r_ball_y <= w_y_step[7:0];
                r_dir_y  <= w_y_step[8];
            end

            // Host reposition comes after the step so it overrides that axis.
            if (w_host_wr && host_address == 3'd3) r_ball_x <= host_writedata;
            if (w_host_wr && host_address == 3'd4) r_ball_y <= host_writedata;

            if (w_host_wr) begin
                r_write     <= 1'b1;
                r_address   <= host_address;
                r_writedata <= host_writedata;
            end else if (w_mov_wr) begin
                r_write     <= 1'b1;
                r_address   <= w_mov_addr;
                r_writedata <= w_mov_dat;
            end else begin
                r_write     <= 1'b0;
            end
        end
    end

    assign chipselect = r_write;
    assign write      = r_write;
    assign address    = r_address;
    assign writedata  = r_writedata;
    assign busy       = (r_state != S_IDLE);
    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;

endmodule

// File: tb/tb_vga_ball_mover.sv
`timescale 1ns/1ps
module tb_vga_ball_mover;

    logic       clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset, enable, vs, hcs, hwr;
    logic [2:0] haddr;
    logic [7:0] hdata;

    logic       o_cs [2];
    logic       o_wr [2];
    logic       o_busy [2];
    logic [2:0] o_addr [2];
    logic [7:0] o_wd [2];
    logic [7:0] o_bx [2];
    logic [7:0] o_by [2];

    vga_ball_mover dut1 (
        .clk(clk), .reset(reset), .enable(enable), .VGA_VS(vs),
        .host_chipselect(hcs), .host_write(hwr), .host_address(haddr), .host_writedata(hdata),
        .chipselect(o_cs[0]), .write(o_wr[0]), .address(o_addr[0]), .writedata(o_wd[0]),
        .busy(o_busy[0]), .ball_x(o_bx[0]), .ball_y(o_by[0])
    );

    vga_ball_mover #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .VGA_VS(vs),
        .host_chipselect(hcs), .host_write(hwr), .host_address(haddr), .host_writedata(hdata),
        .chipselect(o_cs[1]), .write(o_wr[1]), .address(o_addr[1]), .writedata(o_wd[1]),
        .busy(o_busy[1]), .ball_x(o_bx[1]), .ball_y(o_by[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position/direction per axis, a frame counter, a flag
    // for "step due next cycle" and a count of position writes still owed.
    int fd [2] = '{1, 3};
    int m_x [2], m_y [2], m_dx [2], m_dy [2], m_div [2], m_vsd [2], m_upd [2], m_left [2];
    int e_wr [2], e_addr [2], e_wd [2];
    int log_a [$];
    int log_d [$];
    int cnt3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic axis(input int pos, input int dir, input int d, input int mn, input int mx,
                        output int np, output int nd);
        nd = dir;
        if (dir == 1) begin
            if (pos + d >= mx) begin np = mx; nd = 0; end
            else np = pos + d;
        end else begin
            if (pos <= mn + d) begin np = mn; nd = 1; end
            else np = pos - d;
        end
    endtask

    task automatic model_step(input int k);
        int host, tick, was_idle, nx, ny, ndx, ndy;
        if (reset) begin
            m_x[k] = 128; m_y[k] = 60; m_dx[k] = 1; m_dy[k] = 1;
            m_div[k] = 0; m_vsd[k] = 1; m_upd[k] = 0; m_left[k] = 0;
            e_wr[k] = 0; e_addr[k] = 0; e_wd[k] = 0;
            return;
        end
        host     = (hcs && hwr) ? 1 : 0;
        tick     = (m_vsd[k] == 1 && vs == 1'b0) ? 1 : 0;
        was_idle = (m_upd[k] == 0 && m_left[k] == 0) ? 1 : 0;
        if (host == 1) begin
            e_wr[k] = 1; e_addr[k] = int'(haddr); e_wd[k] = int'(hdata);
        end else if (m_left[k] > 0) begin
            e_wr[k]   = 1;
            e_addr[k] = (m_left[k] == 2) ? 3 : 4;
            e_wd[k]   = (m_left[k] == 2) ? m_x[k] : m_y[k];
            m_left[k]--;
        end else begin
            e_wr[k] = 0;
        end
        if (m_upd[k] == 1) begin
            axis(m_x[k], m_dx[k], 1, 20, 235, nx, ndx);
            axis(m_y[k], m_dy[k], 1, 13, 107, ny, ndy);
            m_x[k] = nx; m_dx[k] = ndx; m_y[k] = ny; m_dy[k] = ndy;
            m_upd[k] = 0; m_left[k] = 2;
        end else if (was_idle == 1 && tick == 1 && enable) begin
            if (m_div[k] == fd[k] - 1) begin m_div[k] = 0; m_upd[k] = 1; end
            else m_div[k]++;
        end
        if (host == 1 && haddr == 3'd3) m_x[k] = int'(hdata);
        if (host == 1 && haddr == 3'd4) m_y[k] = int'(hdata);
        m_vsd[k] = int'(vs);
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr%0d", k),   o_wr[k],   e_wr[k]);
            chk($sformatf("cs%0d", k),   o_cs[k],   e_wr[k]);
            chk($sformatf("addr%0d", k), o_addr[k], e_addr[k]);
            chk($sformatf("wd%0d", k),   o_wd[k],   e_wd[k]);
            chk($sformatf("busy%0d", k), o_busy[k], (m_upd[k] != 0 || m_left[k] != 0) ? 1 : 0);
            chk($sformatf("bx%0d", k),   o_bx[k],   m_x[k]);
            chk($sformatf("by%0d", k),   o_by[k],   m_y[k]);
        end
        if (o_wr[0]) begin log_a.push_back(int'(o_addr[0])); log_d.push_back(int'(o_wd[0])); end
        if (o_wr[1] && o_addr[1] == 3'd3) cnt3++;
    endtask

    task automatic idle_in();
        hcs = 1'b0; hwr = 1'b0; haddr = 3'd0; hdata = 8'd0; vs = 1'b1;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
        hcs = 1'b1; hwr = 1'b1; haddr = a; hdata = d;
    endtask

    // Leaves the bench with cycle 3 (mover x write) visible on the outputs.
    task automatic frame_x();
        vs = 1'b0; step();
        vs = 1'b1; step();
        step();
    endtask

    task automatic frame();
        frame_x();
        repeat (3) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; cnt3 = 0;
        idle_in();

        // Reset state and first update
        step(); step();
        chk("rst_wr", o_wr[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_bx", o_bx[0], 128);
        chk("rst_by", o_by[0], 60);
        reset = 1'b0; step(); step();
        frame_x();
        chk("f1_c3_wr", o_wr[0], 1);
        chk("f1_c3_addr", o_addr[0], 3);
        chk("f1_c3_wd", o_wd[0], 129);
        step();
        chk("f1_c4_addr", o_addr[0], 4);
        chk("f1_c4_wd", o_wd[0], 61);
        step();
        chk("f1_c5_wr", o_wr[0], 0);
        step();

        // X bounce at max
        host_wr(3'd3, 8'd234); step(); idle_in(); step();
        frame_x();
        chk("xmax_addr", o_addr[0], 3);
        chk("xmax_wd", o_wd[0], 235);
        repeat (3) step();
        frame_x();
        chk("xback_wd", o_wd[0], 234);
        repeat (3) step();

        // Contention: host holds addr 0 during cycles 2-3
        log_a.delete(); log_d.delete();
        vs = 1'b0; step();
        vs = 1'b1; step();
        host_wr(3'd0, 8'h55); step();
        chk("cont_c3_addr", o_addr[0], 0);
        chk("cont_c3_wd", o_wd[0], 8'h55);
        step();
        chk("cont_c4_addr", o_addr[0], 0);
        chk("cont_c4_wd", o_wd[0], 8'h55);
        idle_in(); step();
        chk("cont_c5_addr", o_addr[0], 3);
        chk("cont_c5_wd", o_wd[0], 233);
        step();
        chk("cont_c6_addr", o_addr[0], 4);
        step();
        chk("cont_c7_wr", o_wr[0], 0);
        begin
            int n3, n4;
            n3 = 0; n4 = 0;
            foreach (log_a[i]) begin
                if (log_a[i] == 3) n3++;
                if (log_a[i] == 4) n4++;
            end
            chk("cont_n3", n3, 1);
            chk("cont_n4", n4, 1);
        end

        // Host reposition during WR_X
        vs = 1'b0; step();
        vs = 1'b1; step();
        host_wr(3'd3, 8'd50); step();
        chk("rep_c3_addr", o_addr[0], 3);
        chk("rep_c3_wd", o_wd[0], 50);
        idle_in(); step();
        chk("rep_c4_wr", o_wr[0], 1);
        chk("rep_c4_addr", o_addr[0], 3);
        chk("rep_c4_wd", o_wd[0], 50);
        step();
        chk("rep_c5_addr", o_addr[0], 4);
        chk("rep_bx", o_bx[0], 50);
        step();

        // Frame divider of 3 with enable gating
        do_reset();
        cnt3 = 0;
        repeat (6) frame();
        chk("div3_en_updates", cnt3, 2);
        enable = 1'b0; cnt3 = 0;
        repeat (3) frame();
        chk("div3_dis_updates", cnt3, 0);
        enable = 1'b1; cnt3 = 0;
        repeat (2) frame();
        chk("div3_held_2", cnt3, 0);
        frame();
        chk("div3_held_3", cnt3, 1);

        // Y bounce and out-of-range host values
        do_reset();
        host_wr(3'd4, 8'd200); step(); idle_in(); step();
        frame_x(); step();
        chk("ymax_addr", o_addr[0], 4);
        chk("ymax_wd", o_wd[0], 107);
        step(); step();
        host_wr(3'd4, 8'd10); step(); idle_in(); step();
        frame_x(); step();
        chk("ymin_wd", o_wd[0], 13);
        step(); step();
        frame_x(); step();
        chk("yup_wd", o_wd[0], 14);
        step(); step();

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            reset  = ($urandom_range(0, 399) == 0);
            enable = ($urandom_range(0, 9) != 0);
            vs     = ($urandom_range(0, 5) != 0);
            hcs    = ($urandom_range(0, 4) == 0);
            hwr    = ($urandom_range(0, 2) != 0);
            haddr  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 4));
            hdata  = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_ball_mover.md
Name: vga_ball_mover

Overview:
- Controller and bus arbiter placed in front of the VGA ball peripheral's 8-bit write port.
- Once per N frames, detected from VGA_VS, it advances the ball centre by a fixed step and bounces at parameterised limits.
- It issues the resulting position register writes to address 3 (x) and address 4 (y).
- Host writes share the same port with strict priority. Host writes to addresses 3 and 4 also reposition the mover's internal state.

Parameters:
- XMIN, 20: minimum x register value (units of 5 hcount = 2.5 px).
- XMAX, 235: maximum x register value.
- YMIN, 13: minimum y register value (units of 4 lines).
- YMAX, 107: maximum y register value.
- DX, 1: x step per update (1..15).
- DY, 1: y step per update (1..15).
- FRAME_DIV, 1: frames per update (1..255).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = motion updates allowed
- VGA_VS  in  1  vertical sync from the counters, active low
- host_chipselect  in  1  host bus select
- host_write  in  1  host write strobe
- host_address  in  3  host register address
- host_writedata  in  8  host write data
- chipselect  out  1  to peripheral; always equals write
- write  out  1  to peripheral write strobe (registered)
- address  out  3  to peripheral address (registered)
- writedata  out  8  to peripheral data (registered)
- busy  out  1  1 when state != IDLE
- ball_x  out  8  current x register value
- ball_y  out  8  current y register value

Behaviour:
- Reset values:
  - write, chipselect, address, writedata = 0.
  - state = IDLE.
  - ball_x = 128, ball_y = 60.
  - dir_x = dir_y = +.
  - div_cnt = 0.
  - vs_d = 1.
- Frame tick: one cycle where vs_d==1 and VGA_VS==0. vs_d is VGA_VS registered.
- Frame divider:
  - On a tick with enable=1 in IDLE: if div_cnt == FRAME_DIV-1, then div_cnt <= 0 and state <= UPDATE; else div_cnt++.
  - Ticks outside IDLE or with enable=0 are ignored and div_cnt holds.
- FSM: IDLE -> UPDATE (1 cycle) -> WR_X -> WR_Y -> IDLE.
  - UPDATE, x direction +: if ball_x + DX >= XMAX, then x <= XMAX and dir_x <= -; else x += DX.
  - UPDATE, x direction -: if ball_x <= XMIN + DX, then x <= XMIN and dir_x <= +; else x -= DX.
  - UPDATE, y axis: identical rules with YMIN/YMAX/DY.
  - All comparisons use 9-bit unsigned, so there is no wrap-around. Out-of-range values written by the host are clamped by these rules at the next update.
  - WR_X: if host write is absent this cycle, load write=1, address=3, writedata=ball_x, then go to WR_Y. Otherwise stall in WR_X.
  - WR_Y: same, with address=4 and writedata=ball_y, then go to IDLE.
- Arbitration:
  - A host write is host_chipselect && host_write.
  - A host write always wins. Its fields are registered onto the output next cycle, for any address.
  - A stalled mover write retries each cycle. It is never dropped or duplicated.
  - The output bus carries at most one write per cycle, with 1-cycle latency from the decision.
- Host reposition:
  - Host write to address 3 sets ball_x <= host_writedata in the same edge. Address 4 likewise sets ball_y.
  - Direction registers are unchanged.
  - If this coincides with WR_X/WR_Y, the retried mover write sends the new host value.
  - If it coincides with UPDATE, the host value wins and the step is discarded for that axis.
- Default output: any cycle with no granted write registers write=0. address and writedata hold their previous values.
- Timing, no contention, tick detected in cycle 0:
  - UPDATE in cycle 1, WR_X in cycle 2.
  - write=1/address=3 visible in cycle 3; write=1/address=4 visible in cycle 4; write=0 in cycle 5.
- Reset mid-sequence: returns immediately to reset values. No partial write is completed.
- enable deassert mid-sequence: the current sequence completes.

Test Plan:
- Reset: assert reset 2 cycles -> write=0, busy=0, ball_x=128, ball_y=60. The next VGA_VS fall produces writes addr 3 data 129 (cycle 3), then addr 4 data 61 (cycle 4).
- X bounce at max: host writes addr3=234 then waits for a VS fall -> writes addr3=235 and dir_x flips. The following frame writes addr3=234.
- Contention: hold host write addr 0 data 0x55 high during cycles 2-3 of an update -> outputs show addr0/0x55 twice, then addr3 and addr4 in cycles 5 and 6. Exactly one mover write per address.
- Host reposition during WR_X: host writes addr3=50 in cycle 2 -> output addr3 data 50 (host), then addr3 data 50 (mover), then addr4. ball_x=50.
- FRAME_DIV=3 with enable toggled: 6 VS falls with enable=1 -> exactly 2 update sequences. With enable=0, 3 VS falls -> no mover writes and div_cnt unchanged.
- Y bounce at min and out-of-range host value: host sets y=200 with dir_y=+ -> next update writes 107 and flips dir. Host sets y=10 with dir_y=- -> next update writes 13 and dir_y becomes +.
